serial_rx_package: RTL and testbench
====================================

// Module: serial_rx_package
// PURPOSE
//  Receive side of the serial packet link. Deserialises 8N1 UART frames from
//  rx, then packs 2**AddressWidth consecutive words into one wide word.
//  Presents the word with a one-cycle valid strobe.
//  Mirror of the TX packager; byte 0 is received first and lands in data[WordWidth-1:0].
// PARAMETERS
//  AddressWidth      2   log2(words per package); package = 2**AddressWidth words
//  WordWidth         8   data bits per UART frame
//  SerialTimerWidth  8   bit period = 2**SerialTimerWidth clk cycles (same as TX side)
//  TimeoutWidth      12  inter-word gap limit = 2**TimeoutWidth clk cycles
// PORTS
//  clk    in   1                        system clock, all logic on posedge
//  rst    in   1                        asynchronous, active-high reset
//  rx     in   1                        serial line, idle high, asynchronous to clk
//  data   out  2**AddressWidth*WordWidth  last complete package, held until next one
//  valid  out  1                        1-cycle pulse: data just updated
//  busy   out  1                        high while a frame or partial package is in progress
//  error  out  1                        1-cycle pulse: framing error or timeout discard
// BEHAVIOUR
//  Reset (async, rst=1)
//   - data=0, valid=0, busy=0, error=0.
//   - Word counter=0, FSM=IDLE, synchroniser flops=1.
//  Input path
//   - rx passes through 2-FF synchroniser; all decisions use the synchronised value rxs.
//  Bit timing
//   - T=2**SerialTimerWidth, H=T/2.
//   - Timer restarts at every state entry.
//  Frame FSM
//   IDLE   rxs falling edge -> START.
//   START  after H cycles sample rxs:
//            - 1 -> IDLE (glitch, no error).
//            - 0 -> DATA, bit index=0.
//   DATA   every T cycles sample rxs into shift reg, LSB first.
//          After WordWidth samples -> STOP.
//   STOP   after T cycles sample rxs:
//            - 1 -> word complete, -> IDLE.
//            - 0 -> framing error, -> IDLE (resynchronises on the next falling edge).
//  Package assembly
//   - Word complete writes buf[counter*WordWidth +: WordWidth], then counter+1.
//   - Completion of word 2**AddressWidth-1: next cycle data<=buf (all words), valid=1 for one cycle.
//     Counter wraps to 0.
//   - Latency: valid rises 1 clk after the stop-bit mid sample of the last word.
//   - Framing error: drop the current partial package, counter=0, error=1 for one cycle.
//     data is unchanged and valid is not asserted.
//   - Timeout: if counter!=0 and FSM stays IDLE for 2**TimeoutWidth-1 cycles, drop the partial
//     package, counter=0, error=1 for one cycle. The gap counter clears on each word complete.
//   - Timeout measured from the return to IDLE; does not fire while counter=0.
//   - Simultaneous timeout expiry and rxs falling edge: start edge wins, no timeout.
//  busy
//   - busy = (FSM!=IDLE) | (counter!=0). Combinational from registers, glitch-free.
//  Reset mid-frame
//   - Immediate abort to reset values; no valid or error pulse on release.
//  No backpressure
//   - Consumer must capture data on valid.
//   - data holds until the next package overwrites it.
// STRUCTURE
//  Shared package (serial_pkg)
//   - FSM state encodings IDLE/START/DATA/STOP.
//   - Frame constants: start=0, stop=1, LSB-first.
//   - Shared with the TX side.
//  Sub-module serial_rx_core (synchroniser + frame FSM + timer)
//   - Outputs word[WordWidth-1:0], word_done pulse, frame_err pulse, active.
//  Top level adds the word counter, package buffer, timeout counter, and data/valid/error regs.
// TESTING  (bench uses SerialTimerWidth=4, i.e. T=16, for speed)
//  1. Words 11,22,33,44 back-to-back -> data=32'h44332211, valid=1 for exactly 1 clk.
//     busy falls with valid; error stays 0.
//  2. 0 pulse on rx of 5 clks (<H=8) -> no word, counter=0, busy returns to 0 by the 8th clk after the edge.
//  3. Word 1=A5 ok, word 2 stop bit=0 -> error pulse, data unchanged, no valid.
//     Then 01,02,03,04 -> data=32'h04030201.
//  4. Two words then rx idle for 4096 clks -> single error pulse at expiry, busy=0.
//     Next 4 words DE,AD,BE,EF -> data=32'hEFBEADDE.
//  5. rst pulse mid-DATA of word 3 -> outputs at reset values, no pulses after release.
//     Fresh 4-word package received correctly.
//  6. Two packages with zero idle gap between stop and next start -> two valid pulses, both data words correct.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial packet link (RX and TX sides).
// Frame format is 8N1-style: start=0, data LSB first, stop=1.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } serialState_t;

  localparam logic StartBit = 1'b0;
  localparam logic StopBit  = 1'b1;
  localparam bit   LsbFirst = 1'b1;

  // Down-counter reload for a span of n cycles (terminal count is zero).
  function automatic int unsigned spanLoad(input int unsigned n);
    return n - 1;
  endfunction

endpackage

// File: rtl/serial_rx_core.sv
// UART frame receiver: 2-FF synchroniser, frame FSM and bit timer.
// Emits one word per good frame, or a frame error on a bad stop bit.
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge on rxs
// START | half a bit period in, confirm the start bit is still low
// DATA  | one sample per bit period, shifted in LSB first
// STOP  | one bit period later, sample the stop bit
module serial_rx_core
  import serial_pkg::*;
#(
  parameter int WordWidth        = 8,
  parameter int SerialTimerWidth = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [WordWidth-1:0] word,
  output logic                 word_done,
  output logic                 frame_err,
  output logic                 active,
  output logic                 start_det
);

  localparam int IdxWidth = (WordWidth > 1) ? $clog2(WordWidth) : 1;
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(WordWidth - 1);
  localparam logic [SerialTimerWidth-1:0] FullLoad =
    SerialTimerWidth'(spanLoad(2 ** SerialTimerWidth));
  localparam logic [SerialTimerWidth-1:0] HalfLoad =
    SerialTimerWidth'(spanLoad(2 ** (SerialTimerWidth - 1)));

  serialState_t state, nextState;
  logic [SerialTimerWidth-1:0] timer, timerNext;
  logic [WordWidth-1:0] shiftReg, shiftNext;
  logic [IdxWidth-1:0] bitIdx, bitIdxNext;
  logic rxMeta, rxs, rxsPrev;
  logic fallEdge, tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxMeta  <= 1'b1;
      rxs     <= 1'b1;
      rxsPrev <= 1'b1;
    end else begin
      rxMeta  <= rx;
      rxs     <= rxMeta;
      rxsPrev <= rxs;
    end
  end

  assign fallEdge = rxsPrev & ~rxs;
  assign tick     = (timer == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      shiftReg <= '0;
      bitIdx   <= '0;
    end else begin
      state    <= nextState;
      timer    <= timerNext;
      shiftReg <= shiftNext;
      bitIdx   <= bitIdxNext;
    end
  end

  always_comb begin
    nextState  = state;
    timerNext  = timer - 1'b1;
    shiftNext  = shiftReg;
    bitIdxNext = bitIdx;
    word_done  = 1'b0;
    frame_err  = 1'b0;
    start_det  = 1'b0;
    unique case (state)
      IDLE: begin
        timerNext = timer;
        if (fallEdge) begin
          nextState = START;
          timerNext = HalfLoad;
          start_det = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          if (rxs == StartBit) begin
            nextState  = DATA;
            timerNext  = FullLoad;
            bitIdxNext = '0;
          end else begin
            // Low pulse shorter than half a bit: treat as a glitch.
            nextState = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shiftNext = WordWidth'({rxs, shiftReg} >> 1);
          timerNext = FullLoad;
          if (bitIdx == LastIdx) nextState = STOP;
          else bitIdxNext = bitIdx + 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          nextState = IDLE;
          if (rxs == StopBit) word_done = 1'b1;
          else frame_err = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  assign word   = shiftReg;
  assign active = (state != IDLE);

endmodule

// File: rtl/serial_rx_package.sv
// Receive-side packager: collects 2**AddressWidth UART words into one wide
// word, word 0 in the low bits, with valid/error strobes and an idle timeout.
module serial_rx_package
  import serial_pkg::*;
#(
  parameter int AddressWidth     = 2,
  parameter int WordWidth        = 8,
  parameter int SerialTimerWidth = 8,
  parameter int TimeoutWidth     = 12
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    rx,
  output logic [(2**AddressWidth)*WordWidth-1:0] data,
  output logic                                    valid,
  output logic                                    busy,
  output logic                                    error
);

  localparam int Words    = 2 ** AddressWidth;
  localparam int PkgWidth = Words * WordWidth;
  localparam logic [AddressWidth-1:0] LastWord = AddressWidth'(Words - 1);
  // Terminal count reached on the (2**TimeoutWidth - 1)th idle cycle.
  localparam logic [TimeoutWidth-1:0] GapLoad =
    TimeoutWidth'(spanLoad(2 ** TimeoutWidth - 1));

  logic [WordWidth-1:0] word;
  logic wordDone, frameErr, active, startDet;
  logic [AddressWidth-1:0] counter;
  logic [PkgWidth-1:0] pkgBuf, merged;
  logic [TimeoutWidth-1:0] gapTimer;
  logic timeoutHit;

  serial_rx_core #(
    .WordWidth        (WordWidth),
    .SerialTimerWidth (SerialTimerWidth)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .word      (word),
    .word_done (wordDone),
    .frame_err (frameErr),
    .active    (active),
    .start_det (startDet)
  );

  always_comb begin
    merged = pkgBuf;
    merged[counter*WordWidth +: WordWidth] = word;
  end

  // A start edge in the expiry cycle wins over the timeout.
  assign timeoutHit = !active && (counter != '0) && (gapTimer == '0) && !startDet;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data    <= '0;
      valid   <= 1'b0;
      error   <= 1'b0;
      counter <= '0;
      pkgBuf  <= '0;
    end else begin
      valid <= 1'b0;
      error <= 1'b0;
      if (wordDone) begin
        pkgBuf  <= merged;
        counter <= counter + 1'b1;
        if (counter == LastWord) begin
          data  <= merged;
          valid <= 1'b1;
        end
      end else if (frameErr || timeoutHit) begin
        counter <= '0;
        error   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gapTimer <= GapLoad;
    end else if (active || (counter == '0)) begin
      gapTimer <= GapLoad;
    end else if (gapTimer != '0) begin
      gapTimer <= gapTimer - 1'b1;
    end
  end

  assign busy = active | (counter != '0);

endmodule

// File: tb/tb_serial_rx_package.sv
// Directed bench for serial_rx_package with a 16-cycle bit period.
module tb_serial_rx_package;

  localparam int BitCycles = 16;

  logic        clk;
  logic        rst;
  logic        rx;
  logic [31:0] data;
  logic        valid;
  logic        busy;
  logic        error;

  int tests = 0;
  int fails = 0;

  int validCnt = 0;
  int errCnt   = 0;
  logic busyAtValid = 1'b1;
  logic [31:0] capt [0:3];

  serial_rx_package #(
    .AddressWidth     (2),
    .WordWidth        (8),
    .SerialTimerWidth (4),
    .TimeoutWidth     (12)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .rx    (rx),
    .data  (data),
    .valid (valid),
    .busy  (busy),
    .error (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (valid) begin
        if (validCnt < 4) capt[validCnt] = data;
        validCnt    = validCnt + 1;
        busyAtValid = busy;
      end
      if (error) errCnt = errCnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clearMon();
    validCnt    = 0;
    errCnt      = 0;
    busyAtValid = 1'b1;
    for (int i = 0; i < 4; i++) capt[i] = '0;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives the first 'slots' bit slots of a frame: start, 8 data LSB first, stop.
  task automatic sendFrame(input logic [7:0] b, input logic stopVal, input int slots);
    logic [9:0] f;
    f = {stopVal, b, 1'b0};
    for (int i = 0; i < slots; i++) begin
      rx = f[i];
      repeat (BitCycles) @(negedge clk);
    end
  endtask

  task automatic sendWord(input logic [7:0] b);
    sendFrame(b, 1'b1, 10);
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    clearMon();
    repeat (3) @(negedge clk);
    check("reset_data", data, 32'h0);
    check("reset_valid", {31'b0, valid}, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_error", {31'b0, error}, 32'h0);
    rst = 1'b0;
    idle(5);

    // 1: one clean package
    clearMon();
    sendWord(8'h11); sendWord(8'h22); sendWord(8'h33); sendWord(8'h44);
    idle(20);
    check("t1_valid_cycles", validCnt, 1);
    check("t1_capt", capt[0], 32'h44332211);
    check("t1_data_hold", data, 32'h44332211);
    check("t1_busy_at_valid", {31'b0, busyAtValid}, 32'h0);
    check("t1_no_error", errCnt, 0);
    check("t1_busy_idle", {31'b0, busy}, 32'h0);

    // 2: 5-cycle low glitch
    clearMon();
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    check("t2_busy_in_start", {31'b0, busy}, 32'h1);
    repeat (6) @(negedge clk);
    check("t2_busy_released", {31'b0, busy}, 32'h0);
    idle(200);
    check("t2_no_valid", validCnt, 0);
    check("t2_no_error", errCnt, 0);
    check("t2_data_kept", data, 32'h44332211);

    // 3: framing error on word 2, then a good package
    clearMon();
    sendWord(8'hA5);
    sendFrame(8'h5A, 1'b0, 10);
    idle(20);
    check("t3_err_cycles", errCnt, 1);
    check("t3_no_valid", validCnt, 0);
    check("t3_data_kept", data, 32'h44332211);
    check("t3_busy_after_err", {31'b0, busy}, 32'h0);
    sendWord(8'h01); sendWord(8'h02); sendWord(8'h03); sendWord(8'h04);
    idle(20);
    check("t3_valid_cycles", validCnt, 1);
    check("t3_data", data, 32'h04030201);
    check("t3_err_total", errCnt, 1);

    // 4: timeout after two words
    clearMon();
    sendWord(8'h77); sendWord(8'h88);
    check("t4_busy_partial", {31'b0, busy}, 32'h1);
    idle(4000);
    check("t4_no_early_timeout", errCnt, 0);
    idle(96);
    check("t4_timeout_err", errCnt, 1);
    check("t4_busy_after", {31'b0, busy}, 32'h0);
    check("t4_no_valid", validCnt, 0);
    sendWord(8'hDE); sendWord(8'hAD); sendWord(8'hBE); sendWord(8'hEF);
    idle(20);
    check("t4_data", data, 32'hEFBEADDE);
    check("t4_valid_cycles", validCnt, 1);
    check("t4_err_total", errCnt, 1);

    // 5: reset in the middle of word 3
    clearMon();
    sendWord(8'hC1); sendWord(8'hC2);
    sendFrame(8'hC3, 1'b1, 5);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_rst_data", data, 32'h0);
    check("t5_rst_busy", {31'b0, busy}, 32'h0);
    check("t5_rst_valid", {31'b0, valid}, 32'h0);
    check("t5_rst_error", {31'b0, error}, 32'h0);
    clearMon();
    rst = 1'b0;
    idle(40);
    check("t5_no_pulses", validCnt + errCnt, 0);
    check("t5_busy_idle", {31'b0, busy}, 32'h0);
    sendWord(8'h5A); sendWord(8'hC3); sendWord(8'h3C); sendWord(8'hA5);
    idle(20);
    check("t5_data", data, 32'hA53CC35A);
    check("t5_valid_cycles", validCnt, 1);

    // 6: two packages with no gap between frames
    clearMon();
    sendWord(8'h10); sendWord(8'h20); sendWord(8'h30); sendWord(8'h40);
    sendWord(8'h55); sendWord(8'h66); sendWord(8'h77); sendWord(8'h88);
    idle(20);
    check("t6_valid_cycles", validCnt, 2);
    check("t6_pkg0", capt[0], 32'h40302010);
    check("t6_pkg1", capt[1], 32'h88776655);
    check("t6_data", data, 32'h88776655);
    check("t6_no_error", errCnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
